decode_stage: RTL and testbench

//  RV32I ID stage between fetch and execute, on the register file's read side.
//  - Decodes the fetched instruction, drives the register-file read ports and generates the immediate.
//  - Registers the result into an ID/EX pipeline register with a valid/ready handshake on both sides.
//  - Inserts a one-cycle bubble on load-use hazards.

---
 rtl/decode_stage.sv | 197 +++++++++++++++++++
 tb/tb_decode_stage.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I decode stage: instruction decode, register-file read, immediate generation and ID/EX register.
// Optional feature: define WB_BYPASS_EN to forward same-cycle writeback data into the operands.
module decode_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  if_valid,
  input  logic [31:0]           if_instr,
  input  logic [XLEN-1:0]       if_pc,
  output logic                  id_ready,
  output logic [REG_ADDR_W-1:0] rs1_addr,
  output logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic [XLEN-1:0]       rs1_data,
  input  logic [XLEN-1:0]       rs2_data,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  output logic                  ex_valid,
  input  logic                  ex_ready,
  output logic [XLEN-1:0]       ex_pc,
  output logic [XLEN-1:0]       ex_rs1_val,
  output logic [XLEN-1:0]       ex_rs2_val,
  output logic [XLEN-1:0]       ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [6:0]            ex_opcode,
  output logic [2:0]            ex_funct3,
  output logic                  ex_funct7b5,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_reg_write,
  output logic                  ex_illegal
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {S_EMPTY, S_FULL, S_BUBBLE} state_t;

  function automatic logic signed [XLEN-1:0] gen_imm(input logic [31:0] instr);
    logic signed [XLEN-1:0] imm;
    imm = '0;
    case (instr[6:0])
      OP_JALR, OP_LOAD, OP_IMM, OP_FENCE, OP_SYSTEM:
        imm = XLEN'($signed(instr[31:20]));
      OP_STORE:
        imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      OP_BRANCH:
        imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      OP_LUI, OP_AUIPC:
        imm = XLEN'($signed({instr[31:12], 12'b0}));
      OP_JAL:
        imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      default: imm = '0;
    endcase
    return imm;
  endfunction

  state_t                  state_q, state_d;
  logic [XLEN-1:0]         ex_pc_q, ex_pc_d, ex_rs1_val_q, ex_rs1_val_d, ex_rs2_val_q, ex_rs2_val_d;
  logic signed [XLEN-1:0]  ex_imm_q, ex_imm_d;
  logic [REG_ADDR_W-1:0]   ex_rd_q, ex_rd_d;
  logic [6:0]              ex_opcode_q, ex_opcode_d;
  logic [2:0]              ex_funct3_q, ex_funct3_d;
  logic                    ex_funct7b5_q, ex_funct7b5_d, ex_mem_read_q, ex_mem_read_d;
  logic                    ex_mem_write_q, ex_mem_write_d, ex_reg_write_q, ex_reg_write_d;
  logic                    ex_illegal_q, ex_illegal_d;

  logic                    legal, reg_wr, mem_rd, mem_wr, uses_rs2, hz, accept;
  logic [XLEN-1:0]         rs1_val, rs2_val;

  assign rs1_addr = if_instr[15 +: REG_ADDR_W];
  assign rs2_addr = if_instr[20 +: REG_ADDR_W];

  always_comb begin
    legal    = 1'b1;
    reg_wr   = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    uses_rs2 = 1'b0;
    case (if_instr[6:0])
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_SYSTEM: reg_wr = 1'b1;
      OP_LOAD:   begin reg_wr = 1'b1; mem_rd = 1'b1; end
      OP_STORE:  begin mem_wr = 1'b1; uses_rs2 = 1'b1; end
      OP_BRANCH: uses_rs2 = 1'b1;
      OP_REG:    begin reg_wr = 1'b1; uses_rs2 = 1'b1; end
      OP_FENCE:  legal = 1'b1;
      default:   legal = 1'b0;
    endcase
    if (if_instr[7 +: REG_ADDR_W] == '0) reg_wr = 1'b0;
  end

  always_comb begin
    rs1_val = (rs1_addr == '0) ? '0 : rs1_data;
    rs2_val = (rs2_addr == '0) ? '0 : rs2_data;
`ifdef WB_BYPASS_EN
    if (wb_en && wb_rd != '0 && wb_rd == rs1_addr) rs1_val = wb_data;
    if (wb_en && wb_rd != '0 && wb_rd == rs2_addr) rs2_val = wb_data;
`endif
  end

`ifndef WB_BYPASS_EN
  logic unused_wb;
  assign unused_wb = ^{wb_en, wb_rd, wb_data};
`endif

  // Load-use hazard: the load in ID/EX cannot forward to the instruction now in decode
  always_comb begin
    hz = (state_q == S_FULL) && ex_mem_read_q && (ex_rd_q != '0) && if_valid &&
         ((ex_rd_q == rs1_addr) || (uses_rs2 && (ex_rd_q == rs2_addr)));
    id_ready = !flush && !hz && ((state_q != S_FULL) || ex_ready);
    accept   = if_valid && id_ready;

    state_d = state_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else if (accept) begin
      state_d = S_FULL;
    end else begin
      case (state_q)
        S_FULL:   if (ex_ready) state_d = hz ? S_BUBBLE : S_EMPTY;
        S_BUBBLE: state_d = S_EMPTY;
        default:  state_d = state_q;
      endcase
    end

    ex_pc_d        = accept ? if_pc : ex_pc_q;
    ex_rs1_val_d   = accept ? rs1_val : ex_rs1_val_q;
    ex_rs2_val_d   = accept ? rs2_val : ex_rs2_val_q;
    ex_imm_d       = accept ? gen_imm(if_instr) : ex_imm_q;
    ex_rd_d        = accept ? (reg_wr ? if_instr[7 +: REG_ADDR_W] : '0) : ex_rd_q;
    ex_opcode_d    = accept ? if_instr[6:0] : ex_opcode_q;
    ex_funct3_d    = accept ? if_instr[14:12] : ex_funct3_q;
    ex_funct7b5_d  = accept ? if_instr[30] : ex_funct7b5_q;
    ex_mem_read_d  = accept ? mem_rd : ex_mem_read_q;
    ex_mem_write_d = accept ? mem_wr : ex_mem_write_q;
    ex_reg_write_d = accept ? reg_wr : ex_reg_write_q;
    ex_illegal_d   = accept ? !legal : ex_illegal_q;
  end

  // ID/EX register boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_EMPTY;
      ex_pc_q        <= '0;
      ex_rs1_val_q   <= '0;
      ex_rs2_val_q   <= '0;
      ex_imm_q       <= '0;
      ex_rd_q        <= '0;
      ex_opcode_q    <= '0;
      ex_funct3_q    <= '0;
      ex_funct7b5_q  <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      ex_mem_write_q <= 1'b0;
      ex_reg_write_q <= 1'b0;
      ex_illegal_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      ex_pc_q        <= ex_pc_d;
      ex_rs1_val_q   <= ex_rs1_val_d;
      ex_rs2_val_q   <= ex_rs2_val_d;
      ex_imm_q       <= ex_imm_d;
      ex_rd_q        <= ex_rd_d;
      ex_opcode_q    <= ex_opcode_d;
      ex_funct3_q    <= ex_funct3_d;
      ex_funct7b5_q  <= ex_funct7b5_d;
      ex_mem_read_q  <= ex_mem_read_d;
      ex_mem_write_q <= ex_mem_write_d;
      ex_reg_write_q <= ex_reg_write_d;
      ex_illegal_q   <= ex_illegal_d;
    end
  end

  assign ex_valid     = (state_q == S_FULL);
  assign ex_pc        = ex_pc_q;
  assign ex_rs1_val   = ex_rs1_val_q;
  assign ex_rs2_val   = ex_rs2_val_q;
  assign ex_imm       = ex_imm_q;
  assign ex_rd        = ex_rd_q;
  assign ex_opcode    = ex_opcode_q;
  assign ex_funct3    = ex_funct3_q;
  assign ex_funct7b5  = ex_funct7b5_q;
  assign ex_mem_read  = ex_mem_read_q;
  assign ex_mem_write = ex_mem_write_q;
  assign ex_reg_write = ex_reg_write_q;
  assign ex_illegal   = ex_illegal_q;
endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage: decode vector table plus hazard, stall, flush and reset sequences.
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        rst, flush, if_valid, wb_en, ex_ready;
  logic [31:0] if_instr, if_pc, rs1_data, rs2_data, wb_data;
  logic [4:0]  wb_rd;
  logic        id_ready, ex_valid, ex_funct7b5, ex_mem_read, ex_mem_write, ex_reg_write, ex_illegal;
  logic [4:0]  rs1_addr, rs2_addr, ex_rd;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .ex_valid(ex_valid),
    .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
    .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
    .ex_funct7b5(ex_funct7b5), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_illegal(ex_illegal)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        rw, mr, mw, ill;
    logic [31:0] rs1v, rs2v;
  } vec_t;

  localparam logic [31:0] R1 = 32'h1111_1111;
  localparam logic [31:0] R2 = 32'h2222_2222;
  localparam logic [31:0] I_ADDI  = 32'h0050_0093;  // addi x1,x0,5
  localparam logic [31:0] I_LW    = 32'h0000_A103;  // lw x2,0(x1)
  localparam logic [31:0] I_ADD   = 32'h0021_01B3;  // add x3,x2,x2
  localparam logic [31:0] I_ADDI2 = 32'h0020_8213;  // addi x4,x1,2 (rs2 field aliases x2)

  vec_t vecs[10];
  logic [31:0] exp_byp;

  initial begin
    vecs[0] = '{I_ADDI,        32'h0000_0005, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, R2};
    vecs[1] = '{I_LW,          32'h0000_0000, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, R1,    32'h0};
    vecs[2] = '{I_ADD,         32'h0000_0000, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, R1,    R2};
    vecs[3] = '{32'hFE00_0EE3, 32'hFFFF_FFFC, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[4] = '{32'hFE53_2C23, 32'hFFFF_FFF8, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, R1,    R2};
    vecs[5] = '{32'h1234_53B7, 32'h1234_5000, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, R1,    R2};
    vecs[6] = '{32'h0080_006F, 32'h0000_0008, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, R2};
    vecs[7] = '{32'h0000_00FF, 32'h0000_0000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0};
    vecs[8] = '{32'hFFF2_0213, 32'hFFFF_FFFF, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, R1,    R2};
    vecs[9] = '{32'h8000_0297, 32'h8000_0000, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};

    rst = 1'b1; flush = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0;
    rs1_data = R1; rs2_data = R2; wb_en = 1'b0; wb_rd = '0; wb_data = '0; ex_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    check("reset_ex_valid", {31'b0, ex_valid}, 32'h0);
    check("reset_ex_rd", {27'b0, ex_rd}, 32'h0);
    check("reset_ex_imm", ex_imm, 32'h0);
    check("reset_ex_pc", ex_pc, 32'h0);
    check("reset_id_ready", {31'b0, id_ready}, 32'h1);

    // Decode table: each vector accepted alone, then drained
    for (int i = 0; i < 10; i++) begin
      if_instr = vecs[i].instr; if_pc = 32'h1000 + 32'(i) * 4; if_valid = 1'b1;
      #1;
      check($sformatf("v%0d_id_ready", i), {31'b0, id_ready}, 32'h1);
      check($sformatf("v%0d_rs1_addr", i), {27'b0, rs1_addr}, {27'b0, vecs[i].instr[19:15]});
      step();
      if_valid = 1'b0;
      check($sformatf("v%0d_ex_valid", i), {31'b0, ex_valid}, 32'h1);
      check($sformatf("v%0d_ex_pc", i), ex_pc, 32'h1000 + 32'(i) * 4);
      check($sformatf("v%0d_ex_imm", i), ex_imm, vecs[i].imm);
      check($sformatf("v%0d_ex_rd", i), {27'b0, ex_rd}, {27'b0, vecs[i].rd});
      check($sformatf("v%0d_ex_flags", i),
            {28'b0, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal},
            {28'b0, vecs[i].rw, vecs[i].mr, vecs[i].mw, vecs[i].ill});
      check($sformatf("v%0d_ex_rs1_val", i), ex_rs1_val, vecs[i].rs1v);
      check($sformatf("v%0d_ex_rs2_val", i), ex_rs2_val, vecs[i].rs2v);
      check($sformatf("v%0d_ex_opcode", i), {25'b0, ex_opcode}, {25'b0, vecs[i].instr[6:0]});
      step();
      check($sformatf("v%0d_drain_valid", i), {31'b0, ex_valid}, 32'h0);
    end

    // Load-use: lw x2 then add x3,x2,x2 -> single bubble
    if_instr = I_LW; if_valid = 1'b1;
    step();
    if_instr = I_ADD;
    #1;
    check("lu_hz_id_ready", {31'b0, id_ready}, 32'h0);
    check("lu_lw_valid", {31'b0, ex_valid}, 32'h1);
    step();
    check("lu_bubble_valid", {31'b0, ex_valid}, 32'h0);
    check("lu_bubble_id_ready", {31'b0, id_ready}, 32'h1);
    step();
    check("lu_add_valid", {31'b0, ex_valid}, 32'h1);
    check("lu_add_rd", {27'b0, ex_rd}, 32'h3);
    if_valid = 1'b0;
    step();

    // I-format after load: rs2 field matches x2 but must not stall
    if_instr = I_LW; if_valid = 1'b1;
    step();
    if_instr = I_ADDI2;
    #1;
    check("nohz_id_ready", {31'b0, id_ready}, 32'h1);
    step();
    check("nohz_addi_rd", {27'b0, ex_rd}, 32'h4);
    check("nohz_addi_valid", {31'b0, ex_valid}, 32'h1);
    if_valid = 1'b0;
    step();

    // Back-pressure: hold 3 cycles, then next instr enters
    if_instr = I_ADDI; if_valid = 1'b1;
    step();
    ex_ready = 1'b0; if_instr = I_ADD;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("stall%0d_id_ready", c), {31'b0, id_ready}, 32'h0);
      check($sformatf("stall%0d_valid", c), {31'b0, ex_valid}, 32'h1);
      check($sformatf("stall%0d_rd", c), {27'b0, ex_rd}, 32'h1);
      check($sformatf("stall%0d_imm", c), ex_imm, 32'h5);
      step();
    end
    ex_ready = 1'b1;
    #1;
    check("release_id_ready", {31'b0, id_ready}, 32'h1);
    step();
    ex_ready = 1'b0;
    check("release_add_rd", {27'b0, ex_rd}, 32'h3);
    check("release_add_valid", {31'b0, ex_valid}, 32'h1);

    // Flush while FULL with a new instr presented
    if_instr = I_ADDI; flush = 1'b1;
    #1;
    check("flush_id_ready", {31'b0, id_ready}, 32'h0);
    step();
    flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
    check("flush_valid", {31'b0, ex_valid}, 32'h0);
    check("flush_not_latched", {27'b0, ex_rd}, 32'h3);

    // Writeback bypass (or its absence in the default build)
    if_instr = 32'h0000_8293; rs1_data = 32'h0; wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'h0000_DEAD;
    if_valid = 1'b1;
`ifdef WB_BYPASS_EN
    exp_byp = 32'h0000_DEAD;
`else
    exp_byp = 32'h0;
`endif
    step();
    if_valid = 1'b0;
    check("byp_hit_rs1", ex_rs1_val, exp_byp);
    step();
    wb_rd = 5'd0; if_valid = 1'b1;
    step();
    if_valid = 1'b0;
    check("byp_rd0_rs1", ex_rs1_val, 32'h0);
    wb_en = 1'b0;
    step();

    // Reset mid-operation discards state and the in-flight handshake
    rs1_data = R1; if_instr = I_LW; if_valid = 1'b1;
    step();
    if_instr = I_ADDI; rst = 1'b1;
    step();
    rst = 1'b0; if_valid = 1'b0;
    check("rst_mid_valid", {31'b0, ex_valid}, 32'h0);
    check("rst_mid_rd", {27'b0, ex_rd}, 32'h0);
    check("rst_mid_mem_read", {31'b0, ex_mem_read}, 32'h0);
    check("rst_mid_pc", ex_pc, 32'h0);
    if_instr = I_ADDI; if_valid = 1'b1;
    step();
    if_valid = 1'b0;
    check("post_rst_valid", {31'b0, ex_valid}, 32'h1);
    check("post_rst_imm", ex_imm, 32'h5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
